fip_32_sqrt_arbiter: RTL and testbench

Round-robin scheduler that shares one iterative fip_32_sqrt unit between N_REQ requesters, such as vector-normal and distance stages in the ray pipeline. It latches the winning radicand, issues a one-cycle enable to the sqrt unit, and waits for its o_valid. It then returns the root to the granted requester with a one-hot response pulse. A watchdog aborts a hung operation with an error response.

---
 rtl/fip_pkg.sv | 27 ++
 rtl/fip_rr_arbiter.sv | 50 +++++
 rtl/fip_32_sqrt_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_fip_32_sqrt_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fip_pkg.sv
// ---------------------------------------------------------------------------
// fip_pkg
// Shared fixed-point (Q16.16) types and constants for the fip_* blocks, plus
// the state encoding of the shared square-root scheduler.
//
// Contents:
//   fip32_t           signed Q16.16 value
//   FIP_MIN/FIP_MAX   most negative / most positive Q16.16 value
//   FIP_ONE           1.0 in Q16.16
//   sqrt_arb_state_e  IDLE / ISSUE / WAIT / RESP
// ---------------------------------------------------------------------------
package fip_pkg;

  typedef logic signed [31:0] fip32_t;

  localparam fip32_t FIP_MIN = 32'sh8000_0000;
  localparam fip32_t FIP_MAX = 32'sh7FFF_FFFF;
  localparam fip32_t FIP_ONE = 32'sh0001_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sqrt_arb_state_e;

endpackage : fip_pkg

// File: rtl/fip_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fip_rr_arbiter
// Purely combinational round-robin pick. Scans the request vector starting at
// the pointer position, wrapping from N_REQ-1 back to 0, and returns the first
// set bit both as a one-hot vector and as a binary index.
//
// Parameters:
//   N_REQ   number of requesters (2..8)
// Ports:
//   i_req    [N_REQ-1:0]  request vector
//   i_ptr    [IDX_W-1:0]  highest-priority position for this pick
//   o_gnt    [N_REQ-1:0]  one-hot winner (all zero when no request)
//   o_idx    [IDX_W-1:0]  binary winner index (zero when no request)
//   o_valid               at least one request present
// ---------------------------------------------------------------------------
module fip_rr_arbiter
  import fip_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Walk the candidates in priority order; the first hit wins and the
  // o_valid flag blocks every later candidate.
  always_comb begin
    int cand;
    cand    = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(i_ptr) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!o_valid && i_req[cand]) begin
        o_valid     = 1'b1;
        o_idx       = IDX_W'(cand);
        o_gnt[cand] = 1'b1;
      end
    end
  end

endmodule : fip_rr_arbiter

// File: rtl/fip_32_sqrt_arbiter.sv
// ---------------------------------------------------------------------------
// fip_32_sqrt_arbiter
// Round-robin scheduler sharing one iterative fip_32_sqrt unit between N_REQ
// requesters. The winning radicand is latched, a one-cycle enable is sent to
// the sqrt unit, and its o_valid is awaited. The root goes back to the granted
// requester with a one-hot response pulse. A watchdog turns a hung operation
// into an error response (root 0, o_rsp_err 1).
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  cycles spent in WAIT before the op is aborted
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_req  [N_REQ]     request levels, held until the matching o_gnt bit
//   i_rad  [N_REQ][32] per-requester unsigned Q16.16 radicand
//   o_gnt  [N_REQ]     one-hot grant pulse (request consumed)
//   o_rsp_valid [N_REQ] one-hot response pulse
//   o_root [32]        result for the pulsed requester (0 outside RESP)
//   o_rsp_err          response is a timeout
//   o_busy             FSM not in IDLE
//   o_sqrt_en          enable pulse to fip_32_sqrt
//   o_sqrt_rad [32]    radicand to fip_32_sqrt
//   i_sqrt_root/i_sqrt_busy/i_sqrt_valid  fip_32_sqrt status and result
//
// Optional build macro FIP_SQRT_ARB_STATS_EN adds:
//   o_stat_ops [N_REQ][16]  per-requester completed-op counters (saturating)
//   o_stat_timeouts [16]    timed-out op counter (saturating)
// ---------------------------------------------------------------------------
module fip_32_sqrt_arbiter
  import fip_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ-1:0][31:0] i_rad,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic [31:0]            o_root,
  output logic                   o_rsp_err,
  output logic                   o_busy,
  output logic                   o_sqrt_en,
  output logic [31:0]            o_sqrt_rad,
  input  logic [31:0]            i_sqrt_root,
  input  logic                   i_sqrt_busy,
  input  logic                   i_sqrt_valid
`ifdef FIP_SQRT_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][15:0] o_stat_ops,
  output logic [15:0]            o_stat_timeouts
`endif
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sqrt_arb_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [31:0]      rad_q, rad_d;
  logic [31:0]      root_q, root_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  fip_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .i_req   (i_req),
    .i_ptr   (ptr_q),
    .o_gnt   (arb_gnt),
    .o_idx   (arb_idx),
    .o_valid (arb_valid)
  );

  // State and operand registers. Reset drops any op in flight silently.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gnt_q   <= '0;
      rad_q   <= '0;
      root_q  <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The one-hot winner is kept alongside its index so the
  // grant and response pulses need no decode. In WAIT a valid from the sqrt
  // unit is tested before the watchdog, so it wins on a tie.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    rad_d   = rad_q;
    root_d  = root_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid && !i_sqrt_busy) begin
          idx_d   = arb_idx;
          gnt_d   = arb_gnt;
          rad_d   = i_rad[arb_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (idx_q == IDX_W'(N_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = idx_q + IDX_W'(1);
        end
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_sqrt_valid) begin
          root_d  = i_sqrt_root;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          root_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the registered state so each pulse lasts
  // exactly one cycle and everything is zero while reset is applied.
  always_comb begin
    o_gnt       = '0;
    o_rsp_valid = '0;
    o_root      = '0;
    o_rsp_err   = 1'b0;
    o_sqrt_en   = 1'b0;
    o_sqrt_rad  = '0;
    o_busy      = (state_q != IDLE);
    unique case (state_q)
      ISSUE: begin
        o_gnt      = gnt_q;
        o_sqrt_en  = 1'b1;
        o_sqrt_rad = rad_q;
      end
      WAIT: begin
        o_sqrt_rad = rad_q;
      end
      RESP: begin
        o_rsp_valid = gnt_q;
        o_root      = root_q;
        o_rsp_err   = err_q;
      end
      default: begin
      end
    endcase
  end

`ifdef FIP_SQRT_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] stat_ops_q;
  logic [15:0]            stat_to_q;

  // Saturating usage counters, bumped once per response. A timed-out op
  // counts as a completed op for its requester and also as a timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stat_ops_q <= '0;
      stat_to_q  <= '0;
    end else if (state_q == RESP) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_q[i] && (stat_ops_q[i] != 16'hFFFF)) begin
          stat_ops_q[i] <= stat_ops_q[i] + 16'd1;
        end
      end
      if (err_q && (stat_to_q != 16'hFFFF)) begin
        stat_to_q <= stat_to_q + 16'd1;
      end
    end
  end

  assign o_stat_ops      = stat_ops_q;
  assign o_stat_timeouts = stat_to_q;
`endif

endmodule : fip_32_sqrt_arbiter

// File: tb/tb_fip_32_sqrt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fip_32_sqrt_arbiter
// Bench for fip_32_sqrt_arbiter with a behavioural stand-in for fip_32_sqrt
// (fixed latency, exact integer square root, optional hang mode) and an
// input that forces the sqrt busy line high.
// ---------------------------------------------------------------------------
module tb_fip_32_sqrt_arbiter;

  localparam int N_REQ    = 4;
  localparam int TIMEOUT  = 64;
  localparam int SQRT_LAT = 4;

  typedef struct {
    logic [3:0]       setReq;
    logic [3:0][31:0] rad;
    logic [3:0]       expGnt;
    logic [31:0]      expRoot;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0][31:0] rad;
  logic [3:0]       oGnt;
  logic [3:0]       oRspValid;
  logic [31:0]      oRoot;
  logic             oRspErr;
  logic             oBusy;
  logic             oSqrtEn;
  logic [31:0]      oSqrtRad;
  logic [31:0]      sqrtRoot;
  logic             sqrtBusy;
  logic             sqrtValid;
`ifdef FIP_SQRT_ARB_STATS_EN
  logic [3:0][15:0] statOps;
  logic [15:0]      statTimeouts;
`endif

  logic        stubHang;
  logic        forceBusy;
  logic        stubBusy;
  logic [31:0] stubRad;
  int          stubCnt;

  int checks;
  int errors;

  vec_t vecs[10];

  fip_32_sqrt_arbiter #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_rad        (rad),
    .o_gnt        (oGnt),
    .o_rsp_valid  (oRspValid),
    .o_root       (oRoot),
    .o_rsp_err    (oRspErr),
    .o_busy       (oBusy),
    .o_sqrt_en    (oSqrtEn),
    .o_sqrt_rad   (oSqrtRad),
    .i_sqrt_root  (sqrtRoot),
    .i_sqrt_busy  (sqrtBusy),
    .i_sqrt_valid (sqrtValid)
`ifdef FIP_SQRT_ARB_STATS_EN
    ,
    .o_stat_ops      (statOps),
    .o_stat_timeouts (statTimeouts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sqrtBusy = stubBusy | forceBusy;

  // Exact floor square root of a 64-bit value, bit by bit.
  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [63:0] res;
    logic [63:0] t;
    res = '0;
    for (int b = 31; b >= 0; b--) begin
      t = res | (64'd1 << b);
      if (t * t <= v) res = t;
    end
    return res[31:0];
  endfunction

  // Stand-in sqrt unit: Q16.16 root of the radicand, valid SQRT_LAT cycles
  // after the enable edge; in hang mode it ignores the enable entirely.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stubBusy  <= 1'b0;
      sqrtValid <= 1'b0;
      sqrtRoot  <= '0;
      stubRad   <= '0;
      stubCnt   <= 0;
    end else begin
      sqrtValid <= 1'b0;
      if (oSqrtEn && !stubHang) begin
        stubBusy <= 1'b1;
        stubCnt  <= SQRT_LAT - 1;
        stubRad  <= oSqrtRad;
      end else if (stubBusy) begin
        if (stubCnt == 0) begin
          sqrtValid <= 1'b1;
          stubBusy  <= 1'b0;
          sqrtRoot  <= isqrt({stubRad, 16'h0000});
        end else begin
          stubCnt <= stubCnt - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] setReq, input logic [3:0][31:0] r);
    rad = r;
    req = req | setReq;
  endtask

  function automatic vec_t mkVec(input logic [3:0] s, input logic [31:0] r0, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] r3,
                                 input logic [3:0] g, input logic [31:0] root);
    vec_t v;
    v.setReq  = s;
    v.rad[0]  = r0;
    v.rad[1]  = r1;
    v.rad[2]  = r2;
    v.rad[3]  = r3;
    v.expGnt  = g;
    v.expRoot = root;
    return v;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_gnt"}, {28'd0, oGnt}, 32'd0);
    checkOutput({tag, "_rspValid"}, {28'd0, oRspValid}, 32'd0);
    checkOutput({tag, "_root"}, oRoot, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, oRspErr}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
    checkOutput({tag, "_sqrtEn"}, {31'd0, oSqrtEn}, 32'd0);
    checkOutput({tag, "_sqrtRad"}, oSqrtRad, 32'd0);
  endtask

  // Wait (bounded) for the next response and compare it; returns how many
  // falling edges it took.
  task automatic waitResponse(input string tag, input logic [3:0] expRsp, input logic [31:0] expRoot,
                              input logic expErr, output int lat);
    int k;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (oRspValid != 4'd0) break;
    end
    lat = k;
    checkOutput({tag, "_rspValid"}, {28'd0, oRspValid}, {28'd0, expRsp});
    checkOutput({tag, "_root"}, oRoot, expRoot);
    checkOutput({tag, "_err"}, {31'd0, oRspErr}, {31'd0, expErr});
  endtask

  // One table row, entered on a falling edge with the DUT idle: raise the
  // row's requests, expect the grant at the next falling edge, drop the
  // granted request during ISSUE, then expect the response SQRT_LAT+2 edges
  // after the grant.
  task automatic runRow(input vec_t v, input string tag);
    int k;
    int lat;
    applyStimulus(v.setReq, v.rad);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (oGnt != 4'd0) break;
    end
    checkOutput({tag, "_gntLat"}, k, 32'd0);
    checkOutput({tag, "_gnt"}, {28'd0, oGnt}, {28'd0, v.expGnt});
    req = req & ~oGnt;
    waitResponse(tag, v.expGnt, v.expRoot, 1'b0, lat);
    checkOutput({tag, "_rspLat"}, lat, SQRT_LAT + 2);
  endtask

  initial begin
    int k;
    int lat;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req       = '0;
    rad       = '0;
    stubHang  = 1'b0;
    forceBusy = 1'b0;

    // Rows 0-3: all four at once from pointer 0; rows 4-9: single requests
    // and the pointer-at-2 fairness case (req3 before req0).
    vecs[0] = mkVec(4'b1111, 32'h0001_0000, 32'h0004_0000, 32'h0009_0000, 32'h0010_0000, 4'b0001, 32'h0001_0000);
    vecs[1] = mkVec(4'b0000, 32'h0001_0000, 32'h0004_0000, 32'h0009_0000, 32'h0010_0000, 4'b0010, 32'h0002_0000);
    vecs[2] = mkVec(4'b0000, 32'h0001_0000, 32'h0004_0000, 32'h0009_0000, 32'h0010_0000, 4'b0100, 32'h0003_0000);
    vecs[3] = mkVec(4'b0000, 32'h0001_0000, 32'h0004_0000, 32'h0009_0000, 32'h0010_0000, 4'b1000, 32'h0004_0000);
    vecs[4] = mkVec(4'b0001, 32'h0004_0000, 32'h0,         32'h0,         32'h0,         4'b0001, 32'h0002_0000);
    vecs[5] = mkVec(4'b0010, 32'h0,         32'h0002_0000, 32'h0,         32'h0,         4'b0010, 32'h0001_6A09);
    vecs[6] = mkVec(4'b1001, 32'h0019_0000, 32'h0,         32'h0,         32'h0064_0000, 4'b1000, 32'h000A_0000);
    vecs[7] = mkVec(4'b0000, 32'h0019_0000, 32'h0,         32'h0,         32'h0064_0000, 4'b0001, 32'h0005_0000);
    vecs[8] = mkVec(4'b0100, 32'h0,         32'h0,         32'h0,         32'h0,         4'b0100, 32'h0000_0000);
    vecs[9] = mkVec(4'b0100, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0,         4'b0100, 32'h00FF_FFFF);

    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      runRow(vecs[i], $sformatf("row%0d", i));
      @(negedge clk);
    end

    // Busy gating: nothing may be issued while the sqrt unit reports busy.
    $display("[TB] busy gating");
    forceBusy = 1'b1;
    rad[1]    = 32'h0001_0000;
    req[1]    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("busyHold%0d", i), {27'd0, oGnt, oSqrtEn}, 32'd0);
    end
    forceBusy = 1'b0;
    @(negedge clk);
    checkOutput("busyRelease_gnt", {28'd0, oGnt}, 32'h2);
    req = req & ~oGnt;
    waitResponse("busyRelease", 4'b0010, 32'h0001_0000, 1'b0, lat);
    @(negedge clk);

    // Watchdog: the sqrt stand-in never answers.
    $display("[TB] timeout");
    stubHang = 1'b1;
    rad[0]   = 32'h0001_0000;
    req[0]   = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (oGnt != 4'd0) break;
    end
    checkOutput("timeout_gnt", {28'd0, oGnt}, 32'h1);
    req = req & ~oGnt;
    waitResponse("timeout", 4'b0001, 32'h0, 1'b1, lat);
    checkOutput("timeout_lat", lat, TIMEOUT + 1);
    @(negedge clk);
    checkOutput("timeout_idle", {31'd0, oBusy}, 32'd0);
    stubHang = 1'b0;

    // Reset in WAIT: everything clears at once, no response, and the still
    // held request is served fresh afterwards.
    $display("[TB] reset mid-wait");
    rad[2] = 32'h0009_0000;
    req[2] = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (oGnt != 4'd0) break;
    end
    checkOutput("midReset_gnt", {28'd0, oGnt}, 32'h4);
    repeat (2) @(negedge clk);
    checkOutput("midReset_busyBefore", {31'd0, oBusy}, 32'd1);
    rst = 1'b1;
    #1;
    checkIdleOutputs("midReset");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midResetNoRsp%0d", i), {28'd0, oRspValid}, 32'd0);
    end
    rst = 1'b0;
    runRow(mkVec(4'b0100, 32'h0, 32'h0, 32'h0009_0000, 32'h0, 4'b0100, 32'h0003_0000), "afterReset");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fip_32_sqrt_arbiter
